conv_layer_host: RTL and testbench
==================================

# conv_layer_host

Host-side counterpart of the CONV accelerator interface: it starts a run with the ready/busy handshake, serves the grayscale image to the accelerator, and acts as the layer-memory responder for the cwr/crd/csel ports. After the run it streams any layer bank out through a valid/ready dump port. It sits between the system controller and the CONV engine.

## Interface
- IMG_AW, 12, image/layer address width (64x64 image)
- DW, 20, pixel/layer data width (signed 4.16 fixed point)
- L0_DEPTH, 4096, words in bank csel=3'b001
- L1_DEPTH, 1024, words in bank csel=3'b011
- L2_DEPTH, 2048, words in bank csel=3'b101
- ARM_TIMEOUT, 255, cycles ready is held without busy before giving up
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to launch a run (honoured only in IDLE)
- done  out  1  one-cycle pulse when a run completes
- err  out  1  sticky error flag
- ready  out  1  to CONV: run request
- busy  in  1  from CONV: engine active
- iaddr  in  IMG_AW  image address from CONV
- idata  out  DW  image data to CONV (combinational from img_data)
- img_addr  out  IMG_AW  to external image ROM (combinational copy of iaddr)
- img_data  in  DW  from external image ROM
- cwr  in  1  layer write strobe
- caddr_wr  in  IMG_AW  layer write address
- cdata_wr  in  DW  layer write data
- crd  in  1  layer read strobe
- caddr_rd  in  IMG_AW  layer read address
- cdata_rd  out  DW  layer read data
- csel  in  3  bank select
- dump_start  in  1  one-cycle request to stream a bank (IDLE only)
- dump_sel  in  3  bank to dump, sampled with dump_start
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer accepts beat
- dump_addr  out  IMG_AW  address of current beat
- dump_data  out  DW  data of current beat
- dump_last  out  1  final beat of bank

## Operation
- States: IDLE, ARM, RUN, DUMP.
- IDLE: start -> ARM, err cleared. dump_start with a mapped dump_sel -> DUMP; unmapped -> err=1, stay IDLE. start and dump_start together: start wins.
- ARM: ready=1. busy sampled 1 -> RUN, ready=0 from the same edge. ARM_TIMEOUT cycles without busy -> err=1, IDLE.
- RUN: ready=0. busy sampled 0 -> done pulse for one cycle, IDLE.
- DUMP: beats addr 0..depth-1 of the selected bank, dump_last on addr depth-1. A beat transfers on dump_valid&&dump_ready; addr/data/last are stable while dump_valid&&!dump_ready. After the last transfer -> IDLE.
- Bank access: writes and reads are accepted in any state except DUMP (dropped there, err=1). Unmapped csel, or address >= bank depth: write dropped, read returns 0, err=1.
- Same bank, same address, cwr and crd in the same cycle: read returns the old data.
- Memory contents are not cleared by reset.

## Timing
- Reset values: ready=0, done=0, err=0, cdata_rd=0, dump_valid=0, dump_addr=0, dump_data=0, dump_last=0, state IDLE. idata/img_addr follow their inputs.
- start -> ready high on the next edge. busy rise -> ready low on the edge it is sampled.
- busy fall sampled -> done high for the following cycle.
- Layer write commits on the edge where cwr=1.
- Read: cdata_rd is registered, valid the cycle after crd=1, and held until the next crd.
- DUMP: the first dump_valid comes 2 cycles after dump_start, because of the one-cycle RAM read. Afterward, with dump_ready held high, one beat per cycle: the next address is prefetched.
- Reset asserted mid-run or mid-dump: immediate return to IDLE and all outputs at reset values. No done pulse.

## Test plan
- Handshake: start; CONV model raises busy 3 cycles later, holds it 50 cycles -> ready high 3 cycles then low, done pulse exactly 1 cycle after the busy fall, err=0.
- Timeout: start with busy held 0 -> ready high 255 cycles, then ready=0, err=1, state IDLE; a later start clears err.
- Layer RW: csel=001, write 20'h0ABCD at addr 100; crd addr 100 the next cycle -> cdata_rd=20'h0ABCD one cycle later. Same-cycle write 20'h1 and read at addr 100 -> old 20'h0ABCD.
- Illegal access: csel=011 write at addr 1024; csel=010 read -> write dropped, read returns 0, err=1.
- Dump backpressure: bank L1 filled with data = address. dump_sel=011; dump_ready toggles 1,0,0,1 -> beats 0..1023 in order, each held while stalled, dump_last only on addr 1023, then IDLE.
- Reset mid-dump: assert reset at beat 500 -> dump_valid=0 immediately. A new dump_start restarts at addr 0 with data intact.

Source files
------------

// File: rtl/conv_layer_host.sv
// Host-side partner of the CONV engine: run handshake, image pass-through,
// three-bank layer memory responder and a valid/ready bank dump streamer.
module conv_layer_host #(
    parameter int IMG_AW      = 12,
    parameter int DW          = 20,
    parameter int L0_DEPTH    = 4096,
    parameter int L1_DEPTH    = 1024,
    parameter int L2_DEPTH    = 2048,
    parameter int ARM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              err,
    output logic              ready,
    input  logic              busy,
    input  logic [IMG_AW-1:0] iaddr,
    output logic [DW-1:0]     idata,
    output logic [IMG_AW-1:0] img_addr,
    input  logic [DW-1:0]     img_data,
    input  logic              cwr,
    input  logic [IMG_AW-1:0] caddr_wr,
    input  logic [DW-1:0]     cdata_wr,
    input  logic              crd,
    input  logic [IMG_AW-1:0] caddr_rd,
    output logic [DW-1:0]     cdata_rd,
    input  logic [2:0]        csel,
    input  logic              dump_start,
    input  logic [2:0]        dump_sel,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [IMG_AW-1:0] dump_addr,
    output logic [DW-1:0]     dump_data,
    output logic              dump_last
);
    // state  | meaning
    // IDLE   | waiting for start or dump_start
    // ARM    | ready high, waiting for busy (bounded by ARM_TIMEOUT)
    // RUN    | engine busy, waiting for busy to drop
    // DUMP   | streaming the selected bank out of the dump port
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DUMP} state_t;

    localparam int L0_W = $clog2(L0_DEPTH);
    localparam int L1_W = $clog2(L1_DEPTH);
    localparam int L2_W = $clog2(L2_DEPTH);
    localparam int TW   = $clog2(ARM_TIMEOUT + 1);
    localparam logic [2:0] SEL_L0 = 3'b001;
    localparam logic [2:0] SEL_L1 = 3'b011;
    localparam logic [2:0] SEL_L2 = 3'b101;

    state_t            state;
    logic [DW-1:0]     mem0 [L0_DEPTH];
    logic [DW-1:0]     mem1 [L1_DEPTH];
    logic [DW-1:0]     mem2 [L2_DEPTH];
    logic [TW-1:0]     timer;
    logic [2:0]        dsel;
    logic [IMG_AW-1:0] fptr;
    logic              in_dump, wr_ok, rd_ok, fsm_err, err_set, err_clr;

    assign idata    = img_data;
    assign img_addr = iaddr;

    // Unmapped selects report depth 0, so one range compare covers both faults.
    function automatic logic [IMG_AW:0] bank_depth(input logic [2:0] sel);
        case (sel)
            SEL_L0:  return (IMG_AW+1)'(L0_DEPTH);
            SEL_L1:  return (IMG_AW+1)'(L1_DEPTH);
            SEL_L2:  return (IMG_AW+1)'(L2_DEPTH);
            default: return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] bank_rd(input logic [2:0] sel, input logic [IMG_AW-1:0] addr);
        case (sel)
            SEL_L0:  return mem0[addr[L0_W-1:0]];
            SEL_L1:  return mem1[addr[L1_W-1:0]];
            SEL_L2:  return mem2[addr[L2_W-1:0]];
            default: return '0;
        endcase
    endfunction

    always_comb begin
        in_dump = (state == S_DUMP);
        wr_ok   = cwr && !in_dump && ({1'b0, caddr_wr} < bank_depth(csel));
        rd_ok   = crd && !in_dump && ({1'b0, caddr_rd} < bank_depth(csel));
        fsm_err = ((state == S_IDLE) && !start && dump_start && (bank_depth(dump_sel) == '0))
               || ((state == S_ARM) && !busy && (timer == '0));
        err_set = (cwr && !wr_ok) || (crd && !rd_ok) || fsm_err;
        err_clr = (state == S_IDLE) && start;
    end

    // Memory has no reset: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            case (csel)
                SEL_L0:  mem0[caddr_wr[L0_W-1:0]] <= cdata_wr;
                SEL_L1:  mem1[caddr_wr[L1_W-1:0]] <= cdata_wr;
                SEL_L2:  mem2[caddr_wr[L2_W-1:0]] <= cdata_wr;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ready      <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cdata_rd   <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
            timer      <= '0;
            dsel       <= '0;
            fptr       <= '0;
        end else begin
            done <= 1'b0;
            err  <= err_set || (err && !err_clr);
            if (crd && !in_dump) begin
                cdata_rd <= rd_ok ? bank_rd(csel, caddr_rd) : '0;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ARM;
                        ready <= 1'b1;
                        timer <= TW'(ARM_TIMEOUT - 1);
                    end else if (dump_start && (bank_depth(dump_sel) != '0)) begin
                        state <= S_DUMP;
                        dsel  <= dump_sel;
                        fptr  <= '0;
                    end
                end
                S_ARM: begin
                    if (busy) begin
                        state <= S_RUN;
                        ready <= 1'b0;
                    end else if (timer == '0) begin
                        state <= S_IDLE;
                        ready <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_RUN: begin
                    if (!busy) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                S_DUMP: begin
                    // Output register doubles as the read stage; refill whenever it drains.
                    if (dump_valid && dump_ready && dump_last) begin
                        state      <= S_IDLE;
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                    end else if (!dump_valid || dump_ready) begin
                        dump_valid <= 1'b1;
                        dump_addr  <= fptr;
                        dump_data  <= bank_rd(dsel, fptr);
                        dump_last  <= ({1'b0, fptr} == bank_depth(dsel) - (IMG_AW+1)'(1));
                        fptr       <= fptr + IMG_AW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_layer_host.sv
// Self-checking bench for conv_layer_host: vector table, random layer traffic
// against an array model, and hand sequences for handshake, timeout and dump.
module tb_conv_layer_host;
    localparam int DW = 20;

    logic clk = 1'b0;
    logic reset, start, busy, cwr, crd, dump_start, dump_ready;
    logic [2:0] csel, dump_sel;
    logic [11:0] iaddr, caddr_wr, caddr_rd, img_addr, dump_addr;
    logic [DW-1:0] img_data, cdata_wr, idata, cdata_rd, dump_data;
    logic done, err, ready, dump_valid, dump_last;

    always #5 clk = ~clk;

    conv_layer_host dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .err(err),
        .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .img_addr(img_addr), .img_data(img_data), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel), .dump_start(dump_start), .dump_sel(dump_sel),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_last(dump_last)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] m0 [4096];
    logic [DW-1:0] m1 [1024];
    logic [DW-1:0] m2 [2048];
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    logic          pat [4];

    typedef struct {
        logic          we;
        logic          re;
        logic [2:0]    sel;
        int            wa;
        logic [DW-1:0] wd;
        int            ra;
        logic [DW-1:0] xrd;
        logic          xerr;
    } vec_t;
    vec_t vt [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int depth_of(input logic [2:0] sel);
        case (sel)
            3'b001:  return 4096;
            3'b011:  return 1024;
            3'b101:  return 2048;
            default: return 0;
        endcase
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [2:0] sel, input int a);
        if (a >= depth_of(sel)) return '0;
        case (sel)
            3'b001:  return m0[a[11:0]];
            3'b011:  return m1[a[9:0]];
            default: return m2[a[10:0]];
        endcase
    endfunction

    task automatic model_wr(input logic [2:0] sel, input int a, input logic [DW-1:0] d);
        if (a < depth_of(sel)) begin
            case (sel)
                3'b001:  m0[a[11:0]] = d;
                3'b011:  m1[a[9:0]]  = d;
                default: m2[a[10:0]] = d;
            endcase
        end
    endtask

    // Drives one layer-port cycle (sampled on the next edge) and updates the model.
    task automatic drive_layer(input logic we, input logic re, input logic [2:0] sel,
                               input int wa, input logic [DW-1:0] wd, input int ra);
        cwr = we; crd = re; csel = sel;
        caddr_wr = 12'(wa); caddr_rd = 12'(ra); cdata_wr = wd;
        if (we) model_wr(sel, wa, wd);
    endtask

    task automatic hs(input int d, input int h);
        start = 1'b1;
        step;
        start = 1'b0;
        for (int n = 1; n <= d + h + 4; n++) begin
            chk("hs_ready", 32'(ready), 32'(n <= d));
            chk("hs_done", 32'(done), 32'(n == 1 + d + h));
            chk("hs_err", 32'(err), 32'(0));
            busy = (n + 1 >= 1 + d) && (n + 1 <= d + h);
            step;
        end
        busy = 1'b0;
    endtask

    task automatic dump_run(input string nm, input int mode, input int stop_at);
        int   idx;
        int   cyc;
        logic xfer;
        idx = 0;
        cyc = 0;
        dump_sel = 3'b011;
        dump_start = 1'b1;
        step;
        dump_start = 1'b0;
        while (idx < 1024 && cyc < 5000) begin
            dump_ready = (mode == 0) ? pat[cyc % 4] : 1'b1;
            if (cyc == 0) chk({nm, "_lat"}, 32'(dump_valid), 32'(0));
            if (cyc == 1 || (mode == 1 && cyc >= 1)) chk({nm, "_valid"}, 32'(dump_valid), 32'(1));
            if (dump_valid) begin
                chk({nm, "_addr"}, 32'(dump_addr), 32'(idx));
                chk({nm, "_data"}, 32'(dump_data), 32'(model_rd(3'b011, idx)));
                chk({nm, "_last"}, 32'(dump_last), 32'(idx == 1023));
                if (idx == stop_at) begin
                    reset = 1'b0;
                    #1;
                    chk("rst_dump_valid", 32'(dump_valid), 32'(0));
                    chk("rst_dump_addr", 32'(dump_addr), 32'(0));
                    chk("rst_dump_data", 32'(dump_data), 32'(0));
                    chk("rst_dump_last", 32'(dump_last), 32'(0));
                    chk("rst_ready", 32'(ready), 32'(0));
                    chk("rst_done", 32'(done), 32'(0));
                    chk("rst_err", 32'(err), 32'(0));
                    chk("rst_cdata_rd", 32'(cdata_rd), 32'(0));
                    @(posedge clk);
                    #1;
                    reset = 1'b1;
                    dump_ready = 1'b0;
                    exp_rd = '0;
                    exp_err = 1'b0;
                    break;
                end
            end
            xfer = dump_valid && dump_ready;
            step;
            cyc++;
            if (xfer) idx++;
        end
        if (stop_at < 0) begin
            if (idx < 1024) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_budget: %0d of 1024 beats after %0d cycles", nm, idx, cyc);
            end
            if (mode == 1) chk({nm, "_cycles"}, 32'(cyc), 32'(1025));
            chk({nm, "_end_valid"}, 32'(dump_valid), 32'(0));
            chk({nm, "_end_last"}, 32'(dump_last), 32'(0));
            dump_ready = 1'b0;
        end
    endtask

    initial begin
        logic [2:0]    sel;
        logic [DW-1:0] wd;
        logic          we, re;
        int            wa, ra, dpt;

        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        vt[0]  = '{1'b1, 1'b0, 3'b001, 100,  20'h0ABCD, 0,    20'h00000, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 3'b001, 0,    20'h00000, 100,  20'h0ABCD, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 3'b001, 100,  20'h00001, 100,  20'h0ABCD, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 3'b001, 0,    20'h00000, 100,  20'h00001, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 3'b011, 0,    20'h33333, 0,    20'h00001, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 3'b011, 1024, 20'h00005, 0,    20'h00001, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 3'b011, 0,    20'h00000, 0,    20'h33333, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 3'b010, 0,    20'h00000, 7,    20'h00000, 1'b1};
        vt[8]  = '{1'b1, 1'b0, 3'b101, 2047, 20'h7FFFF, 0,    20'h00000, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 3'b101, 0,    20'h00000, 2047, 20'h7FFFF, 1'b1};
        vt[10] = '{1'b0, 1'b1, 3'b101, 0,    20'h00000, 2048, 20'h00000, 1'b1};

        reset = 1'b0; start = 1'b0; busy = 1'b0; cwr = 1'b0; crd = 1'b0;
        dump_start = 1'b0; dump_ready = 1'b0; csel = 3'b000; dump_sel = 3'b000;
        iaddr = '0; caddr_wr = '0; caddr_rd = '0; img_data = '0; cdata_wr = '0;
        exp_rd = '0; exp_err = 1'b0;
        #3;
        chk("reset_ready", 32'(ready), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_err", 32'(err), 32'(0));
        chk("reset_cdata_rd", 32'(cdata_rd), 32'(0));
        chk("reset_dump_valid", 32'(dump_valid), 32'(0));
        chk("reset_dump_addr", 32'(dump_addr), 32'(0));
        chk("reset_dump_data", 32'(dump_data), 32'(0));
        chk("reset_dump_last", 32'(dump_last), 32'(0));
        for (int i = 0; i < 4; i++) begin
            iaddr = 12'($urandom);
            img_data = 20'($urandom);
            #1;
            chk("img_addr_pass", 32'(img_addr), 32'(iaddr));
            chk("idata_pass", 32'(idata), 32'(img_data));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        step;

        for (int a = 0; a < 4096; a++) begin drive_layer(1'b1, 1'b0, 3'b001, a, 20'($urandom), 0); step; end
        for (int a = 0; a < 1024; a++) begin drive_layer(1'b1, 1'b0, 3'b011, a, 20'($urandom), 0); step; end
        for (int a = 0; a < 2048; a++) begin drive_layer(1'b1, 1'b0, 3'b101, a, 20'($urandom), 0); step; end
        cwr = 1'b0;
        chk("fill_err", 32'(err), 32'(0));

        for (int i = 0; i < 11; i++) begin
            drive_layer(vt[i].we, vt[i].re, vt[i].sel, vt[i].wa, vt[i].wd, vt[i].ra);
            step;
            cwr = 1'b0; crd = 1'b0;
            chk($sformatf("vec%0d_rd", i), 32'(cdata_rd), 32'(vt[i].xrd));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].xerr));
            exp_rd = vt[i].xrd;
            exp_err = vt[i].xerr;
        end

        for (int i = 0; i < 1500; i++) begin
            we = 1'($urandom);
            re = 1'($urandom);
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 2))
                    0:       sel = 3'b001;
                    1:       sel = 3'b011;
                    default: sel = 3'b101;
                endcase
            end else begin
                sel = 3'($urandom_range(0, 7));
            end
            dpt = depth_of(sel);
            wa = ($urandom_range(0, 9) < 8 && dpt > 0) ? int'($urandom_range(0, dpt - 1)) : int'($urandom_range(0, 4095));
            ra = ($urandom_range(0, 9) < 8 && dpt > 0) ? int'($urandom_range(0, dpt - 1)) : int'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) == 0) ra = wa;
            wd = 20'($urandom);
            if (re) exp_rd = model_rd(sel, ra);
            if ((we && wa >= dpt) || (re && ra >= dpt)) exp_err = 1'b1;
            drive_layer(we, re, sel, wa, wd, ra);
            step;
            cwr = 1'b0; crd = 1'b0;
            chk("rand_rd", 32'(cdata_rd), 32'(exp_rd));
            chk("rand_err", 32'(err), 32'(exp_err));
        end

        for (int a = 0; a < 1024; a++) begin drive_layer(1'b1, 1'b0, 3'b011, a, 20'(a), 0); step; end
        cwr = 1'b0;

        start = 1'b1;
        step;
        start = 1'b0;
        for (int n = 1; n <= 258; n++) begin
            chk("to_ready", 32'(ready), 32'(n <= 255));
            chk("to_err", 32'(err), 32'(n >= 256));
            step;
        end

        hs(3, 50);
        hs(1, 1);
        for (int i = 0; i < 3; i++) hs(int'($urandom_range(1, 20)), int'($urandom_range(1, 60)));

        dump_sel = 3'b010;
        dump_start = 1'b1;
        step;
        dump_start = 1'b0;
        chk("bad_dump_err", 32'(err), 32'(1));
        for (int i = 0; i < 3; i++) begin
            chk("bad_dump_valid", 32'(dump_valid), 32'(0));
            step;
        end

        dump_run("bp_dump", 0, -1);
        hs(1, 2);
        dump_run("rst_dump", 1, 500);
        dump_run("full_dump", 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
